serial_adder_128: RTL



---
 rtl/serial_adder_128.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/serial_adder_128.sv
// serial_adder_128: multi-cycle add/subtract unit. Each RUN cycle pushes DIGIT
// bits of both operands through a ripple chain of 1-bit full-adder cells. The
// carry is registered between cycles.
module serial_adder_128 #(
  parameter int WIDTH = 128,
  parameter int DIGIT = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = WIDTH - DIGIT;  // digits already produced before the last one

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Ripple chain across one digit; c[DIGIT-1] is the carry into the digit's top bit
  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] sum;

  assign c[0] = carry_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder_1bit u_fa (
      .a   (a_q[i]),
      .b   (b_q[i]),
      .cin (c[i]),
      .s   (sum[i]),
      .cout(c[i+1])
    );
  end

  // Next-state, datapath sequencing and completion flags
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          a_d     = A;
          b_d     = Sub ? ~B : B;
          carry_d = Sub | Cin;    // subtract is A + ~B + 1
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = {sum, acc_q[AW-1:DIGIT]};
        carry_d = c[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          // Last digit holds the MSB, so its internal carries give the flags
          result_d = {sum, acc_q};
          cout_d   = c[DIGIT];
          ovf_d    = c[DIGIT-1] ^ c[DIGIT];
          zero_d   = ({sum, acc_q} == '0);
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign Busy     = (state_q == RUN);
  assign Done     = (state_q == DONE);
  assign Result   = result_q;
  assign Cout     = cout_q;
  assign Overflow = ovf_q;
  assign Zero     = zero_q;
endmodule

// One-bit full-adder cell used in the digit chain
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule
